// File: rtl/uart_cmd_framer_pkg.sv
// rtl/uart_cmd_framer_pkg.sv - shared types and constants for the UART command framer
// Contents: framer state encoding, frame start-bit position, opcode values,
// command payload width and the frame checksum helper.
package uart_cmd_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B1   = 3'd1,
        ST_B2   = 3'd2,
        ST_CHK  = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    localparam int FRAME_START_BIT = 7;

    localparam logic [1:0] OP_OFFSET  = 2'b00;
    localparam logic [1:0] OP_DIVISOR = 2'b01;
    localparam logic [1:0] OP_QUERY   = 2'b10;
    localparam logic [1:0] OP_EXT     = 2'b11;

    localparam int CMD_PAYLOAD_W = 19;

    // Checksum byte of a frame: continuation-style byte carrying the XOR of
    // the low seven bits of the three frame bytes.
    function automatic logic [7:0] chk_byte(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2);
        return {1'b0, b0[6:0] ^ b1[6:0] ^ b2[6:0]};
    endfunction

endpackage

// File: rtl/framer_tx_slot.sv
// rtl/framer_tx_slot.sv - single-entry transmit buffer shared by byte echoes and decoder replies
// Ports:
//   i_clk, i_rst (async, active-low), i_en (slot may accept new bytes)
//   i_echo_fire/i_echo_data   : received byte to echo (always wins)
//   i_reply_valid/i_reply_data/o_reply_ready : decoder reply handshake
//   o_empty                   : slot holds no byte
//   o_tx_data/o_tx_valid/i_tx_ready : UART transmitter handshake
module framer_tx_slot #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_echo_fire,
    input  logic [DATA_WIDTH-1:0] i_echo_data,
    input  logic                  i_reply_valid,
    input  logic [DATA_WIDTH-1:0] i_reply_data,
    output logic                  o_reply_ready,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_reply_fire;

    assign o_empty       = !r_valid;
    // An echo arriving in the same cycle takes the empty slot first.
    assign o_reply_ready = i_en && !r_valid && !i_echo_fire;
    assign w_reply_fire  = i_reply_valid && o_reply_ready;
    assign o_tx_data     = r_data;
    assign o_tx_valid    = r_valid;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_echo_fire) begin
            r_valid <= 1'b1;
            r_data  <= i_echo_data;
        end else if (w_reply_fire) begin
            r_valid <= 1'b1;
            r_data  <= i_reply_data;
        end else if (r_valid && i_tx_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_cmd_framer.sv
// rtl/uart_cmd_framer.sv - assembles framed UART commands, echoes bytes and merges decoder replies
// Optional feature macro: CMD_CHECKSUM_EN (adds a 4th XOR checksum byte, state CHK).
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_rx_data/i_rx_valid/o_rx_ready       : bytes from the UART receiver
//   o_tx_data/o_tx_valid/i_tx_ready       : bytes to the UART transmitter
//   i_reply_data/i_reply_valid/o_reply_ready : reply bytes from the decoder
//   o_cmd_valid/i_cmd_ready/o_cmd_op/o_cmd_payload : held command word
//   o_frame_err (1-cycle pulse), o_err_count (saturating fault count)
module uart_cmd_framer
    import uart_cmd_framer_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int TO_WIDTH       = 20
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DATA_WIDTH-1:0]    i_rx_data,
    input  logic                     i_rx_valid,
    output logic                     o_rx_ready,
    output logic [DATA_WIDTH-1:0]    o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    input  logic [DATA_WIDTH-1:0]    i_reply_data,
    input  logic                     i_reply_valid,
    output logic                     o_reply_ready,
    output logic                     o_cmd_valid,
    input  logic                     i_cmd_ready,
    output logic [1:0]               o_cmd_op,
    output logic [CMD_PAYLOAD_W-1:0] o_cmd_payload,
    output logic                     o_frame_err,
    output logic [7:0]               o_err_count
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_en;
    logic [1:0]           r_op;
    logic [4:0]           r_hi;
    logic [6:0]           r_mid;
    logic [6:0]           r_lo;
    logic [TO_WIDTH-1:0]  r_to_cnt;
    logic                 r_frame_err;
    logic [7:0]           r_err_count;

    logic w_slot_empty;
    logic w_rx_fire;
    logic w_start;
    logic w_to_run;
    logic w_timeout;
    logic w_ld_b0;
    logic w_ld_b1;
    logic w_ld_b2;
    logic w_fault;

    // r_en keeps both ready outputs low while reset is asserted.
    assign o_rx_ready    = r_en && w_slot_empty && (r_state != ST_HOLD);
    assign w_rx_fire     = i_rx_valid && o_rx_ready;
    assign w_start       = i_rx_data[FRAME_START_BIT];
    assign w_to_run      = (r_state == ST_B1) || (r_state == ST_B2) || (r_state == ST_CHK);
    assign w_timeout     = (r_to_cnt == TO_WIDTH'(TIMEOUT_CYCLES));

    assign o_cmd_valid   = (r_state == ST_HOLD);
    assign o_cmd_op      = r_op;
    assign o_cmd_payload = {r_hi, r_mid, r_lo};
    assign o_frame_err   = r_frame_err;
    assign o_err_count   = r_err_count;

    framer_tx_slot #(.DATA_WIDTH(DATA_WIDTH)) u_tx_slot (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (r_en),
        .i_echo_fire   (w_rx_fire),
        .i_echo_data   (i_rx_data),
        .i_reply_valid (i_reply_valid),
        .i_reply_data  (i_reply_data),
        .o_reply_ready (o_reply_ready),
        .o_empty       (w_slot_empty),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready)
    );

    // A received byte always takes precedence over a timeout in the same
    // cycle, so a resync byte and an expiring counter yield one fault.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_b0     = 1'b0;
        w_ld_b1     = 1'b0;
        w_ld_b2     = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    if (w_start) begin
                        w_ld_b0     = 1'b1;
                        w_state_nxt = ST_B1;
                    end else begin
                        w_fault = 1'b1;
                    end
                end
            end
            ST_B1: begin
                if (w_rx_fire) begin
                    if (w_start) begin
                        w_fault = 1'b1;
                        w_ld_b0 = 1'b1;
                    end else begin
                        w_ld_b1     = 1'b1;
                        w_state_nxt = ST_B2;
                    end
                end else if (w_timeout) begin
                    w_fault     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_B2: begin
                if (w_rx_fire) begin
                    if (w_start) begin
                        w_fault     = 1'b1;
                        w_ld_b0     = 1'b1;
                        w_state_nxt = ST_B1;
                    end else begin
                        w_ld_b2     = 1'b1;
`ifdef CMD_CHECKSUM_EN
                        w_state_nxt = ST_CHK;
`else
                        w_state_nxt = ST_HOLD;
`endif
                    end
                end else if (w_timeout) begin
                    w_fault     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef CMD_CHECKSUM_EN
            ST_CHK: begin
                if (w_rx_fire) begin
                    if (w_start) begin
                        w_fault     = 1'b1;
                        w_ld_b0     = 1'b1;
                        w_state_nxt = ST_B1;
                    end else if (i_rx_data == chk_byte({1'b1, r_op, r_hi}, {1'b0, r_mid}, {1'b0, r_lo})) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_fault     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_fault     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            ST_HOLD: begin
                if (i_cmd_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_en        <= 1'b0;
            r_op        <= '0;
            r_hi        <= '0;
            r_mid       <= '0;
            r_lo        <= '0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_en        <= 1'b1;
            r_frame_err <= w_fault;
            if (w_fault && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (w_rx_fire || !w_to_run || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_ld_b0) begin
                r_op <= i_rx_data[6:5];
                r_hi <= i_rx_data[4:0];
            end
            if (w_ld_b1) begin
                r_mid <= i_rx_data[6:0];
            end
            if (w_ld_b2) begin
                r_lo <= i_rx_data[6:0];
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb/tb_uart_cmd_framer.sv - directed self-checking bench for uart_cmd_framer
module tb_uart_cmd_framer;
    import uart_cmd_framer_pkg::*;

    localparam int TO = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  reply_data = '0;
    logic        reply_valid = 1'b0;
    logic        reply_ready;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_op;
    logic [18:0] cmd_payload;
    logic        frame_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    uart_cmd_framer #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(TO), .TO_WIDTH(20)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .i_reply_data(reply_data), .i_reply_valid(reply_valid), .o_reply_ready(reply_ready),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_op(cmd_op),
        .o_cmd_payload(cmd_payload), .o_frame_err(frame_err), .o_err_count(err_count)
    );

    int checks = 0;
    int failures = 0;
    int n_err = 0;
    int n_reply = 0;
    int n_cmd = 0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (frame_err) n_err++;
        if (reply_valid && reply_ready) n_reply++;
        if (cmd_valid && cmd_ready) n_cmd++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        rx_data = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (rx_ready) got = 1'b1;
        end
        step();
        rx_valid = 1'b0;
        if (got) exp_q.push_back(b);
        chk("rx_accept", 32'(got), 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
`ifdef CMD_CHECKSUM_EN
        send_byte(chk_byte(b0, b1, b2));
`endif
    endtask

    task automatic take_cmd(output logic [1:0] op, output logic [18:0] pl);
        bit got;
        got = 1'b0;
        op = 'x;
        pl = 'x;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (cmd_valid) begin
                got = 1'b1;
                op = cmd_op;
                pl = cmd_payload;
            end
        end
        chk("cmd_seen", 32'(got), 32'd1);
        step();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
    endtask

    task automatic chk_tx();
        repeat (4) step();
        chk("tx_count", tx_q.size(), exp_q.size());
        for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("tx_byte%0d", i), 32'(tx_q[i]), 32'(exp_q[i]));
        end
        tx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [1:0]  op;
        logic [18:0] pl;
        int          e0, c0, good;
        bit          rxh, rph, first_rr;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_reply_ready", 32'(reply_ready), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_op", 32'(cmd_op), 32'd0);
        chk("rst_cmd_payload", 32'(cmd_payload), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        step();
        rst = 1'b1;
        step();
        step();

        // Basic frame, held for 100 clocks with cmd_ready low
        c0 = n_cmd;
        send_frame(8'h81, 8'h05, 8'h7F);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmd_valid) break;
        end
        good = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1 && rx_ready === 1'b0 && cmd_op === OP_OFFSET && cmd_payload === 19'h042FF)
                good++;
        end
        chk("hold_cycles", 32'(good), 32'd100);
        step();
        take_cmd(op, pl);
        chk("t1_op", 32'(op), 32'(OP_OFFSET));
        chk("t1_payload", 32'(pl), 32'h042FF);
        @(negedge clk);
        chk("t1_cmd_count", 32'(n_cmd - c0), 32'd1);
        chk("t1_cmd_valid_low", 32'(cmd_valid), 32'd0);
        chk("t1_rx_ready_back", 32'(rx_ready), 32'd1);
        chk("t1_err_count", 32'(err_count), 32'd0);
        step();
        chk_tx();

        // Resync: A0 then C3 restarts the frame
        e0 = n_err;
        send_byte(8'hA0);
        send_frame(8'hC3, 8'h01, 8'h02);
        take_cmd(op, pl);
        chk("t2_op", 32'(op), 32'(OP_QUERY));
        chk("t2_payload", 32'(pl), 32'h0C082);
        chk("t2_err_pulses", 32'(n_err - e0), 32'd1);
        chk("t2_err_count", 32'(err_count), 32'd1);
        chk_tx();

        // Stray continuation byte in IDLE, then a timed-out partial frame
        e0 = n_err;
        c0 = n_cmd;
        send_byte(8'h05);
        send_byte(8'h81);
        repeat (TO - 5) step();
        chk("t3_before_timeout", 32'(n_err - e0), 32'd1);
        repeat (15) step();
        chk("t3_after_timeout", 32'(n_err - e0), 32'd2);
        chk("t3_err_count", 32'(err_count), 32'd3);
        chk("t3_no_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("t3_no_cmd", 32'(n_cmd - c0), 32'd0);
        send_byte(8'h22);
        repeat (3) step();
        chk("t3_back_in_idle", 32'(n_err - e0), 32'd3);
        chk_tx();

        // Echo and reply offered in the same cycle: echo first
        e0 = n_reply;
        rx_data = 8'h90;
        rx_valid = 1'b1;
        reply_data = 8'h58;
        reply_valid = 1'b1;
        first_rr = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rxh = rx_valid && rx_ready;
            rph = reply_valid && reply_ready;
            if (k == 0) first_rr = reply_ready;
            step();
            if (rxh) rx_valid = 1'b0;
            if (rph) reply_valid = 1'b0;
            if (!rx_valid && !reply_valid) break;
        end
        exp_q.push_back(8'h90);
        exp_q.push_back(8'h58);
        chk("t5_reply_blocked", 32'(first_rr), 32'd0);
        chk_tx();
        chk("t5_reply_once", 32'(n_reply - e0), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef CMD_CHECKSUM_EN
        send_byte(chk_byte(8'h90, 8'h00, 8'h00));
`endif
        take_cmd(op, pl);
        chk("t5_op", 32'(op), 32'(OP_OFFSET));
        chk("t5_payload", 32'(pl), 32'h40000);

        // Payload/opcode extremes
        send_frame(8'hBF, 8'h7F, 8'h7F);
        take_cmd(op, pl);
        chk("t6_op", 32'(op), 32'(OP_DIVISOR));
        chk("t6_payload", 32'(pl), 32'h7FFFF);
        send_frame(8'hE0, 8'h00, 8'h00);
        take_cmd(op, pl);
        chk("t7_op", 32'(op), 32'(OP_EXT));
        chk("t7_payload", 32'(pl), 32'h00000);
        chk_tx();

`ifdef CMD_CHECKSUM_EN
        send_byte(8'h81);
        send_byte(8'h05);
        send_byte(8'h7F);
        send_byte(8'h7B);
        take_cmd(op, pl);
        chk("chk_good_payload", 32'(pl), 32'h042FF);
        e0 = n_err;
        c0 = n_cmd;
        send_byte(8'h81);
        send_byte(8'h05);
        send_byte(8'h7F);
        send_byte(8'h7A);
        repeat (5) step();
        chk("chk_bad_err", 32'(n_err - e0), 32'd1);
        chk("chk_bad_no_cmd", 32'(n_cmd - c0), 32'd0);
        chk("chk_bad_cmd_valid", 32'(cmd_valid), 32'd0);
        chk_tx();
`endif

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send_byte(8'h05);
        end
        repeat (3) step();
        chk("err_saturate", 32'(err_count), 32'd255);
        chk_tx();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
